sgdmac_rd_scheduler: RTL

Read-side scheduler for the SGDMAC. It shares the single AXI AR/R port between N read requesters, such as the descriptor fetcher and the data reader. Arbitration is round-robin with a per-requester outstanding-burst limit. Each granted burst is stamped with the requester index as ARID, and returning R beats are routed back by RID. It replaces the fixed-priority AR arbiter plus the external RID-indexed rready mux, and it tracks in-flight bursts so the top level can qualify its done condition.

---
 rtl/sgdmac_pkg.sv | 43 ++++
 rtl/sgdmac_ot_counter.sv | 43 ++++
 rtl/sgdmac_rd_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sgdmac_pkg.sv
// Shared definitions for the SGDMAC read-side scheduler.
//   - AXI AR field widths
//   - sched_state_t: scheduler FSM states
//   - rr_pick(): round-robin one-hot grant over up to RR_MAX_REQ requesters
package sgdmac_pkg;

  localparam int unsigned AXI_ID_W    = 4;
  localparam int unsigned AXI_ADDR_W  = 32;
  localparam int unsigned AXI_LEN_W   = 4;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;

  // Upper bound on requesters; ARID width limits the index space.
  localparam int unsigned RR_MAX_REQ  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_t;

  // First set bit of req at or after ptr, wrapping modulo n. One-hot result,
  // all zeros when nothing is requested.
  function automatic logic [RR_MAX_REQ-1:0] rr_pick(
    input logic [RR_MAX_REQ-1:0] req,
    input logic [AXI_ID_W-1:0]   ptr,
    input int unsigned           n = RR_MAX_REQ
  );
    logic [RR_MAX_REQ-1:0] gnt;
    logic                  found;
    logic [AXI_ID_W-1:0]   idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < RR_MAX_REQ; off++) begin
      idx = AXI_ID_W'((32'(ptr) + off) % n);
      if ((off < n) && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/sgdmac_ot_counter.sv
// Per-requester outstanding-burst counter.
//   clk, rst     : clock, synchronous active-high reset
//   inc_i        : AR burst accepted for this requester
//   dec_i        : RLAST beat accepted for this requester
//   cnt_o        : bursts in flight
//   full_o       : cnt_o has reached MAX_OUTSTANDING
//   underflow_o  : decrement requested while cnt_o is zero (count held at 0)
module sgdmac_ot_counter #(
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q != CNT_W'(MAX_OUTSTANDING)) cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) underflow_o = 1'b1;
      else             cnt_d       = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q >= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/sgdmac_rd_scheduler.sv
// Read-side scheduler: round-robin AR arbitration between N_MASTER
// requesters with per-requester outstanding limits, ARID = requester index,
// and RID-based routing of R valid/ready.
//   req_ar*_i / req_arready_o : per-requester AR channel (packed, slice k)
//   req_rvalid_o / req_rready_i : per-requester R handshake
//   ar*_o / arready_i : registered AXI AR master
//   rid_i, rlast_i, rvalid_i / rready_o : AXI R control
//   idle_o : no AR pending and nothing in flight
//   err_o  : sticky; unknown RID or RLAST with no burst outstanding
module sgdmac_rd_scheduler
  import sgdmac_pkg::*;
#(
  parameter int unsigned N_MASTER        = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTER-1:0]             req_arvalid_i,
  input  logic [N_MASTER*AXI_ADDR_W-1:0]  req_araddr_i,
  input  logic [N_MASTER*AXI_LEN_W-1:0]   req_arlen_i,
  input  logic [N_MASTER*AXI_SIZE_W-1:0]  req_arsize_i,
  input  logic [N_MASTER*AXI_BURST_W-1:0] req_arburst_i,
  output logic [N_MASTER-1:0]             req_arready_o,
  output logic [N_MASTER-1:0]             req_rvalid_o,
  input  logic [N_MASTER-1:0]             req_rready_i,
  output logic [AXI_ID_W-1:0]             arid_o,
  output logic [AXI_ADDR_W-1:0]           araddr_o,
  output logic [AXI_LEN_W-1:0]            arlen_o,
  output logic [AXI_SIZE_W-1:0]           arsize_o,
  output logic [AXI_BURST_W-1:0]          arburst_o,
  output logic                            arvalid_o,
  input  logic                            arready_i,
  input  logic [AXI_ID_W-1:0]             rid_i,
  input  logic                            rlast_i,
  input  logic                            rvalid_i,
  output logic                            rready_o,
  output logic                            idle_o,
  output logic                            err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  sched_state_t state_q, state_d;
  logic [AXI_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                   arvalid_q, arvalid_d;
  logic [AXI_ID_W-1:0]    arid_q, arid_d;
  logic [AXI_ADDR_W-1:0]  araddr_q, araddr_d;
  logic [AXI_LEN_W-1:0]   arlen_q, arlen_d;
  logic [AXI_SIZE_W-1:0]  arsize_q, arsize_d;
  logic [AXI_BURST_W-1:0] arburst_q, arburst_d;
  logic                   err_q, err_d;

  logic [N_MASTER-1:0]       full, underflow, inc, dec, elig;
  logic [N_MASTER*CNT_W-1:0] cnt_flat;
  logic [RR_MAX_REQ-1:0]     grant;
  logic [AXI_ID_W-1:0]       win_idx;
  logic                      ar_hs, rid_ok, r_beat;

  assign elig  = req_arvalid_i & ~full;
  assign ar_hs = (state_q == ISSUE) & arready_i;
  assign grant = rr_pick(RR_MAX_REQ'(elig), rr_ptr_q, N_MASTER);

  always_comb begin
    win_idx = '0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++)
      if (grant[k]) win_idx = AXI_ID_W'(k);
  end

  // R routing; beats with an unknown RID are drained.
  always_comb begin
    rid_ok       = (rid_i < AXI_ID_W'(N_MASTER));
    req_rvalid_o = '0;
    rready_o     = !rid_ok;
    for (int unsigned k = 0; k < N_MASTER; k++) begin
      if (rid_i == AXI_ID_W'(k)) begin
        req_rvalid_o[k] = rvalid_i;
        rready_o        = req_rready_i[k];
      end
    end
  end

  assign r_beat = rvalid_i & rready_o;

  for (genvar g = 0; g < N_MASTER; g++) begin : g_cnt
    assign inc[g] = ar_hs & (arid_q == AXI_ID_W'(g));
    assign dec[g] = r_beat & rlast_i & (rid_i == AXI_ID_W'(g));

    sgdmac_ot_counter #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (inc[g]),
      .dec_i      (dec[g]),
      .cnt_o      (cnt_flat[g*CNT_W +: CNT_W]),
      .full_o     (full[g]),
      .underflow_o(underflow[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d   = ISSUE;
          arvalid_d = 1'b1;
          arid_d    = win_idx;
          for (int unsigned k = 0; k < N_MASTER; k++) begin
            if (win_idx == AXI_ID_W'(k)) begin
              araddr_d  = req_araddr_i[k*AXI_ADDR_W +: AXI_ADDR_W];
              arlen_d   = req_arlen_i[k*AXI_LEN_W +: AXI_LEN_W];
              arsize_d  = req_arsize_i[k*AXI_SIZE_W +: AXI_SIZE_W];
              arburst_d = req_arburst_i[k*AXI_BURST_W +: AXI_BURST_W];
            end
          end
        end
      end
      ISSUE: begin
        if (arready_i) begin
          state_d   = IDLE;
          arvalid_d = 1'b0;
          rr_ptr_d  = (arid_q == AXI_ID_W'(N_MASTER - 1)) ? '0 : arid_q + AXI_ID_W'(1);
        end
      end
    endcase
  end

  assign err_d = err_q | (rvalid_i & ~rid_ok) | (|underflow);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      err_q     <= err_d;
    end
  end

  assign req_arready_o = inc;
  assign arvalid_o     = arvalid_q;
  assign arid_o        = arid_q;
  assign araddr_o      = araddr_q;
  assign arlen_o       = arlen_q;
  assign arsize_o      = arsize_q;
  assign arburst_o     = arburst_q;
  assign err_o         = err_q;
  assign idle_o        = (state_q == IDLE) & ~(|cnt_flat);

endmodule
